// File: rtl/prng_xoshiro_jump.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prng_xoshiro_jump
//
// Control stage placed in front of a Xoshiro256+ core. While idle it passes the
// user's step / seed-load requests straight to the core. On a jump request it
// takes over the core for 256 step cycles. During those cycles it XOR-accumulates
// the core state wherever the jump polynomial has a 1 bit. It then loads the
// accumulated state back as a seed, which advances the core by 2^128 steps
// (or 2^192 steps for long_jump).
//
// Optional build macro: PRNG_XOSHIRO_JUMP_LONG_EN
//   defined   : i_longJump (latched at acceptance) selects the LONG_JUMP polynomial
//   undefined : only JUMP is built; i_longJump is accepted but ignored
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_userCg, i_userSeedValid       user step / seed-load requests
//   i_userSeedS0..S3                user seed words
//   i_jumpValid, i_longJump         jump request and long-jump qualifier
//   o_jumpReady                     request is accepted when valid & ready
//   o_busy                          jump sequence in progress (step + load)
//   o_done                          one-cycle pulse, new state visible at core
//   i_prngS0..S3                    current core state words
//   o_prngCg, o_prngSeedValid       core step enable and seed load
//   o_prngSeedS0..S3                core seed words
//
// Latency is fixed: accept at edge 0, load in cycle 257, done in cycle 258.
// A reset during a jump aborts it without o_done; the core is left partially
// advanced and must be reseeded.
// -----------------------------------------------------------------------------
module prng_xoshiro_jump (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_userCg,
  input  logic        i_userSeedValid,
  input  logic [63:0] i_userSeedS0,
  input  logic [63:0] i_userSeedS1,
  input  logic [63:0] i_userSeedS2,
  input  logic [63:0] i_userSeedS3,
  input  logic        i_jumpValid,
  input  logic        i_longJump,
  output logic        o_jumpReady,
  output logic        o_busy,
  output logic        o_done,
  input  logic [63:0] i_prngS0,
  input  logic [63:0] i_prngS1,
  input  logic [63:0] i_prngS2,
  input  logic [63:0] i_prngS3,
  output logic        o_prngCg,
  output logic        o_prngSeedValid,
  output logic [63:0] o_prngSeedS0,
  output logic [63:0] o_prngSeedS1,
  output logic [63:0] o_prngSeedS2,
  output logic [63:0] o_prngSeedS3
);

  // Packed so that element [w] is constant word w (word 0 is the least significant).
  localparam logic [3:0][63:0] JUMP_C = {
    64'h39abdc4529b1661c, 64'ha9582618e03fc9aa,
    64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba
  };

  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_LOAD, ST_DONE} state_t;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [63:0] acc_reg  [4];
  logic [63:0] acc_next [4];
  logic [63:0] prng_s   [4];
  logic        busy_reg;
  logic        ready_reg;
  logic        done_reg;
  logic [63:0] const_word;
  logic        const_bit;

  assign prng_s[0] = i_prngS0;
  assign prng_s[1] = i_prngS1;
  assign prng_s[2] = i_prngS2;
  assign prng_s[3] = i_prngS3;

`ifdef PRNG_XOSHIRO_JUMP_LONG_EN
  localparam logic [3:0][63:0] LONG_C = {
    64'h39109bb02acbe635, 64'h77710069854ee241,
    64'hc5004e441c522fb3, 64'h76e15d3efefdcbbf
  };
  logic long_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      long_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && i_jumpValid) begin
      long_reg <= i_longJump;
    end
  end

  assign const_word = long_reg ? LONG_C[cnt_reg[7:6]] : JUMP_C[cnt_reg[7:6]];
`else
  // The port stays so the interface is identical in both builds.
  logic unused_long_jump;
  assign unused_long_jump = i_longJump;
  assign const_word = JUMP_C[cnt_reg[7:6]];
`endif

  // Polynomial bits are consumed LSB first within each word, word 0 first.
  assign const_bit = const_word[cnt_reg[5:0]];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_acc
      assign acc_next[gi] = const_bit ? (acc_reg[gi] ^ prng_s[gi]) : acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) acc_reg[i] <= 64'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_jumpValid) begin
            state_reg <= ST_STEP;
            cnt_reg   <= 8'd0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            for (int i = 0; i < 4; i++) acc_reg[i] <= 64'd0;
          end
        end
        ST_STEP: begin
          for (int i = 0; i < 4; i++) acc_reg[i] <= acc_next[i];
          cnt_reg <= cnt_reg + 8'd1;
          if (cnt_reg == 8'hff) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          state_reg <= ST_DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_reg;
  assign o_jumpReady = ready_reg;
  assign o_done      = done_reg;

  // The core is owned by the jump sequence in STEP and LOAD; otherwise user
  // requests flow straight through (including the acceptance cycle).
  always_comb begin
    o_prngCg        = i_userCg;
    o_prngSeedValid = i_userSeedValid;
    o_prngSeedS0    = i_userSeedS0;
    o_prngSeedS1    = i_userSeedS1;
    o_prngSeedS2    = i_userSeedS2;
    o_prngSeedS3    = i_userSeedS3;
    if (state_reg == ST_STEP || state_reg == ST_LOAD) begin
      o_prngCg        = 1'b1;
      o_prngSeedValid = (state_reg == ST_LOAD);
      o_prngSeedS0    = acc_reg[0];
      o_prngSeedS1    = acc_reg[1];
      o_prngSeedS2    = acc_reg[2];
      o_prngSeedS3    = acc_reg[3];
    end
  end

endmodule

// File: tb/tb_prng_xoshiro_jump.sv
`timescale 1ns/1ps
// Testbench for prng_xoshiro_jump: a behavioural Xoshiro256+ core closes the
// loop, and a reference jump() model computes the expected final state.
module tb_prng_xoshiro_jump;

  typedef logic [3:0][63:0] st_t;

  localparam st_t JUMP_C = {64'h39abdc4529b1661c, 64'ha9582618e03fc9aa,
                            64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba};
  localparam st_t LONG_C = {64'h39109bb02acbe635, 64'h77710069854ee241,
                            64'hc5004e441c522fb3, 64'h76e15d3efefdcbbf};
  localparam st_t S1234  = {64'd4, 64'd3, 64'd2, 64'd1};
  localparam st_t S_ALT  = {64'h0123456789abcdef, 64'hfedcba9876543210,
                            64'h0f1e2d3c4b5a6978, 64'h8badf00ddeadbeef};

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_userCg = 1'b0;
  logic        i_userSeedValid = 1'b0;
  st_t         user_seed = '0;
  logic        i_jumpValid = 1'b0;
  logic        i_longJump = 1'b0;
  logic        o_jumpReady, o_busy, o_done;
  logic        o_prngCg, o_prngSeedValid;
  logic [63:0] o_prngSeedS0, o_prngSeedS1, o_prngSeedS2, o_prngSeedS3;
  st_t         core_s = '0;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  prng_xoshiro_jump dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_userCg(i_userCg), .i_userSeedValid(i_userSeedValid),
    .i_userSeedS0(user_seed[0]), .i_userSeedS1(user_seed[1]),
    .i_userSeedS2(user_seed[2]), .i_userSeedS3(user_seed[3]),
    .i_jumpValid(i_jumpValid), .i_longJump(i_longJump),
    .o_jumpReady(o_jumpReady), .o_busy(o_busy), .o_done(o_done),
    .i_prngS0(core_s[0]), .i_prngS1(core_s[1]),
    .i_prngS2(core_s[2]), .i_prngS3(core_s[3]),
    .o_prngCg(o_prngCg), .o_prngSeedValid(o_prngSeedValid),
    .o_prngSeedS0(o_prngSeedS0), .o_prngSeedS1(o_prngSeedS1),
    .o_prngSeedS2(o_prngSeedS2), .o_prngSeedS3(o_prngSeedS3)
  );

  // ---------------- reference model ----------------
  function automatic st_t xo_next(st_t s);
    st_t r;
    logic [63:0] t;
    r = s;
    t = r[1] << 17;
    r[2] = r[2] ^ r[0];
    r[3] = r[3] ^ r[1];
    r[1] = r[1] ^ r[2];
    r[0] = r[0] ^ r[3];
    r[2] = r[2] ^ t;
    r[3] = {r[3][18:0], r[3][63:19]};  // rotl 45
    return r;
  endfunction

  function automatic st_t jump_model(st_t s, st_t c);
    st_t acc, cur;
    acc = '0;
    cur = s;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 64; b++) begin
        if (c[w][b]) acc = acc ^ cur;
        cur = xo_next(cur);
      end
    end
    return acc;
  endfunction

  // Core model: seed load has priority over a step.
  always @(posedge i_clk) begin
    if (o_prngSeedValid)  core_s <= {o_prngSeedS3, o_prngSeedS2, o_prngSeedS1, o_prngSeedS0};
    else if (o_prngCg)    core_s <= xo_next(core_s);
  end

  // Cycles since acceptance: 0 = idle, 1..256 stepping, 257 load, 258 done.
  int   phase = 0;
  logic long_q = 1'b0;
  st_t  exp_acc = '0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase <= 0;
    end else begin
      if (phase == 0) begin
        if (i_jumpValid) begin
          phase <= 1;
`ifdef PRNG_XOSHIRO_JUMP_LONG_EN
          long_q <= i_longJump;
`else
          long_q <= 1'b0;
`endif
        end
      end else if (phase == 258) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
      end
      // Cycle 1 shows the state the jump starts from.
      if (phase == 1) exp_acc <= jump_model(core_s, long_q ? LONG_C : JUMP_C);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input st_t act, input st_t exp);
    for (int w = 0; w < 4; w++) chk($sformatf("%s[%0d]", name, w), act[w], exp[w]);
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge i_clk) begin
    chk("jumpReady", o_jumpReady, (phase == 0));
    chk("busy", o_busy, (phase >= 1 && phase <= 257));
    chk("done", o_done, (phase == 258));
    if (phase == 0 || phase == 258) begin
      chk("cg_pass", o_prngCg, i_userCg);
      chk("sv_pass", o_prngSeedValid, i_userSeedValid);
      chk_state("seed_pass", {o_prngSeedS3, o_prngSeedS2, o_prngSeedS1, o_prngSeedS0}, user_seed);
    end else begin
      chk("cg_jump", o_prngCg, 1'b1);
      chk("sv_jump", o_prngSeedValid, (phase == 257));
      if (phase == 257)
        chk_state("seed_load", {o_prngSeedS3, o_prngSeedS2, o_prngSeedS1, o_prngSeedS0}, exp_acc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic seed(input st_t s);
    user_seed = s;
    i_userSeedValid = 1'b1;
    i_userCg = 1'b0;
    tick();
    i_userSeedValid = 1'b0;
    chk_state("core_after_seed", core_s, s);
    $display("seed %h %h %h %h", s[0], s[1], s[2], s[3]);
  endtask

  task automatic do_jump(input string name, input logic lng, input logic cg_acc,
                         input bit disturb, input st_t exp_final);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    i_jumpValid = 1'b1;
    i_longJump  = lng;
    i_userCg    = cg_acc;
    tick();
    i_jumpValid = 1'b0;
    i_longJump  = 1'b0;
    i_userCg    = 1'b0;
    for (int n = 1; n <= 400 && done_at == 0; n++) begin
      if (disturb && n == 11) begin
        i_userSeedValid = 1'b1;
        i_jumpValid     = 1'b1;
        i_userCg        = 1'b1;
        user_seed       = {4{64'hdeadbeefcafef00d}};
      end else if (disturb && n == 21) begin
        i_userSeedValid = 1'b0;
        i_jumpValid     = 1'b0;
        i_userCg        = 1'b0;
      end
      @(negedge i_clk);
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_at = n;
        chk_state({name, "_final"}, core_s, exp_final);
      end else begin
        tick();
      end
    end
    tick();
    chk({name, "_busy_cycles"}, busy_cnt, 257);
    chk({name, "_done_cycle"}, done_at, 258);
    $display("jump %s: done cycle %0d busy %0d state %h %h %h %h",
             name, done_at, busy_cnt, core_s[0], core_s[1], core_s[2], core_s[3]);
  endtask

  initial begin
    // Pin the model with hand-derived values.
    chk_state("model_next_1234", xo_next(S1234),
              {64'h0000c00000000000, 64'h0000000000040002, 64'd0, 64'd7});
    chk_state("model_zero_fixed", jump_model('0, JUMP_C), '0);
    chk_state("model_identity", jump_model(S1234, st_t'(1)), S1234);

    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();

    seed(S1234);
    do_jump("jump_1234", 1'b0, 1'b0, 1'b0, jump_model(S1234, JUMP_C));

    seed('0);
    do_jump("jump_zero", 1'b0, 1'b0, 1'b0, '0);

    // Step in the acceptance cycle: jump starts from the stepped state.
    seed(S1234);
    do_jump("jump_cg_accept", 1'b0, 1'b1, 1'b0, jump_model(xo_next(S1234), JUMP_C));

    // User seed/step/jump requests while busy are ignored.
    seed(S1234);
    do_jump("jump_disturb", 1'b0, 1'b0, 1'b1, jump_model(S1234, JUMP_C));
    user_seed = '0;

    // Reset at cnt=100.
    seed(S1234);
    i_jumpValid = 1'b1;
    tick();
    i_jumpValid = 1'b0;
    repeat (100) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_jumpReady, 1'b1);
    chk("rst_done", o_done, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    $display("reset mid-jump applied");
    repeat (5) tick();
    seed(S_ALT);
    do_jump("jump_after_reset", 1'b0, 1'b0, 1'b0, jump_model(S_ALT, JUMP_C));

    seed(S1234);
`ifdef PRNG_XOSHIRO_JUMP_LONG_EN
    do_jump("long_jump", 1'b1, 1'b0, 1'b0, jump_model(S1234, LONG_C));
`else
    do_jump("long_jump", 1'b1, 1'b0, 1'b0, jump_model(S1234, JUMP_C));
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_xoshiro_jump.md
Name: prng_xoshiro_jump

Overview:
- Control stage directly upstream of the Xoshiro256+ PRNG core.
- Drives the core's clock-gate and seed-load inputs, and reads back its four 64-bit state words.
- Implements jump() (2^128 steps) and optionally long_jump() (2^192 steps) in hardware.
- Gives multiple generator instances non-overlapping sequences from one seed; passes user step/seed through unchanged when idle.

Parameters:
- none. Jump constants are fixed localparams.
- JUMP = {0x180ec6d33cfd0aba, 0xd5a61266f0c9392c, 0xa9582618e03fc9aa, 0x39abdc4529b1661c}, word 0 first.
- LONG_JUMP = {0x76e15d3efefdcbbf, 0xc5004e441c522fb3, 0x77710069854ee241, 0x39109bb02acbe635}.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_userCg  input  1  user step request to the PRNG
- i_userSeedValid  input  1  user seed load
- i_userSeedS0..S3  input  64 each  user seed words
- i_jumpValid  input  1  jump request
- i_longJump  input  1  qualifies i_jumpValid: 1=long_jump
- o_jumpReady  output  1  request accepted when valid&ready
- o_busy  output  1  jump in progress
- o_done  output  1  one-cycle pulse, jump complete
- i_prngS0..S3  input  64 each  PRNG current state (core o_s0..o_s3)
- o_prngCg  output  1  to core i_cg
- o_prngSeedValid  output  1  to core i_seedValid
- o_prngSeedS0..S3  output  64 each  to core i_seedS0..S3

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset:
  - State=IDLE, cnt=0, acc[0..3]=0, long flag=0.
  - o_jumpReady=1, o_busy=0, o_done=0.
  - Pass-through outputs follow user inputs.
- FSM states: IDLE, STEP, LOAD, DONE.
- IDLE:
  - o_prngCg=i_userCg, o_prngSeedValid=i_userSeedValid, o_prngSeedSx=i_userSeedSx, o_jumpReady=1.
  - On i_jumpValid: latch i_longJump, clear acc and cnt, go to STEP.
  - A user seed/step in the acceptance cycle takes effect at that edge, so the jump starts from the updated state.
- STEP, 256 cycles, cnt 0..255:
  - Constant word index = cnt[7:6]; bit index = cnt[5:0], LSB first.
  - If the selected constant bit = 1: acc[x] <= acc[x] ^ i_prngSx, for all four words.
  - o_prngCg=1 every cycle, o_prngSeedValid=0.
  - At cnt=255, go to LOAD. cnt is 8-bit; no wrap is used.
- LOAD, 1 cycle: o_prngSeedValid=1, o_prngSeedSx=acc[x], o_prngCg=1. Go to DONE.
- DONE, 1 cycle: o_done=1, pass-through as IDLE, o_jumpReady=0. Go to IDLE.
- Outputs by state:
  - o_busy=1 in STEP and LOAD.
  - o_jumpReady=0 in STEP, LOAD and DONE.
- Latency is fixed and independent of the constant's popcount:
  - Accept at edge 0; LOAD in cycle 257; new state visible at the core in cycle 258; o_done in cycle 258.
- While busy, i_userCg, i_userSeedValid and i_jumpValid are ignored; no queuing.
- Reset mid-jump: immediately IDLE, acc cleared, no o_done. The core is not reset and is left partially advanced; software must reseed.
- Zero state is a fixed point: acc stays 0 and 0 is loaded.
- All arithmetic is XOR only; no carries.

Optional Feature:
- Macro: PRNG_XOSHIRO_JUMP_LONG_EN.
- Defined: i_longJump selects LONG_JUMP constants, latched at acceptance.
- Undefined:
  - LONG_JUMP logic is not built; i_longJump is ignored and JUMP is always used.
  - The port is retained so the interface is unchanged.

Test Plan:
- Reset, then seed (1,2,3,4) in IDLE with i_userCg=0 → o_prngSeedValid=1 the same cycle, o_prngCg=0. Core state=(1,2,3,4), checked against the C model.
- After seed (1,2,3,4), pulse i_jumpValid with i_longJump=0 →
  - o_busy high for exactly 257 cycles; o_prngCg high for those 257 cycles.
  - o_done pulses once in cycle 258.
  - Final core state equals the C model jump() from (1,2,3,4).
- Seed (0,0,0,0), then jump → acc=0, loaded state (0,0,0,0), o_done at cycle 258.
- During a jump at cnt=10, assert i_userSeedValid and i_jumpValid → o_prngSeedValid stays 0 until LOAD, and no second jump starts.
- Assert i_rst_n=0 at cnt=100 →
  - o_busy=0 and o_jumpReady=1 asynchronously; o_done never pulses.
  - A new seed-plus-jump then completes per the C model.
- Long jump from seed (1,2,3,4), i_longJump=1:
  - With PRNG_XOSHIRO_JUMP_LONG_EN → matches C long_jump().
  - Without it → matches C jump().
